// File: rtl/canvas_framebuffer_if.sv
// -----------------------------------------------------------------------------
// canvas_framebuffer_if
//   Pixel write handshake and scan-out read bus of canvas_framebuffer.
//   master : drawing / update logic and VGA pixel generator side
//   slave  : the framebuffer
//   wr_valid/wr_ready  write handshake (accepted when both are high)
//   wr_x, wr_y         screen coordinate of the pixel to modify
//   wr_op              00 set, 01 erase, 10 toggle (XOR), 11 no-op
//   wr_color           colour used by set/toggle
//   rd_x, rd_y         scan-out read coordinate
//   rd_data            pixel value, one cycle after rd_x/rd_y
// -----------------------------------------------------------------------------
interface canvas_framebuffer_if #(
    parameter int unsigned XW  = 10,
    parameter int unsigned YW  = 9,
    parameter int unsigned BPP = 1
);
    logic           wr_valid;
    logic           wr_ready;
    logic [XW-1:0]  wr_x;
    logic [YW-1:0]  wr_y;
    logic [1:0]     wr_op;
    logic [BPP-1:0] wr_color;
    logic [XW-1:0]  rd_x;
    logic [YW-1:0]  rd_y;
    logic [BPP-1:0] rd_data;

    modport master (
        output wr_valid, wr_x, wr_y, wr_op, wr_color, rd_x, rd_y,
        input  wr_ready, rd_data
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_op, wr_color, rd_x, rd_y,
        output wr_ready, rd_data
    );
endinterface

// File: rtl/canvas_framebuffer.sv
// -----------------------------------------------------------------------------
// canvas_framebuffer
//   Word-packed, BPP-bits-per-pixel canvas store with screen-to-canvas
//   down-scaling (coordinates shifted right by SCALE_SHIFT). Pixel writes go
//   through a two-cycle read-modify-write (IDLE -> MODIFY). A hardware sweep
//   initialises every word after reset and on clear_req. A separate read port
//   feeds the VGA scan-out with one cycle of latency.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset (starts a zero-fill sweep)
//   clear_req   pulse: request a clear sweep
//   busy        clear sweep in progress
//   fill_color  sweep colour (only when CANVAS_FILL_EN is defined)
//   bus         canvas_framebuffer_if.slave: write handshake + read port
//
// Build option
//   CANVAS_FILL_EN : adds fill_color; requested sweeps write fill_color
//                    replicated across the word, sampled when the sweep
//                    starts. Reset sweeps always write zeros. Without the
//                    macro every sweep writes zeros.
// -----------------------------------------------------------------------------
module canvas_framebuffer #(
    parameter int unsigned CANVAS_W    = 320,
    parameter int unsigned CANVAS_H    = 240,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned BPP         = 1,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned XW          = 10,
    parameter int unsigned YW          = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_req,
    output logic                 busy,
`ifdef CANVAS_FILL_EN
    input  logic [BPP-1:0]       fill_color,
`endif
    canvas_framebuffer_if.slave  bus
);

    localparam int unsigned PPW   = WORD_W / BPP;
    localparam int unsigned WORDS = (CANVAS_W * CANVAS_H + PPW - 1) / PPW;
    localparam int unsigned AW    = $clog2(WORDS);
    localparam int unsigned SW    = (PPW > 1) ? $clog2(PPW) : 1;

    typedef enum logic [1:0] {CLEAR, IDLE, MODIFY} state_t;

    typedef struct packed {
        logic          ok;
        logic [AW-1:0] word;
        logic [SW-1:0] slot;
    } loc_t;

    // Screen coordinate -> (in range, word address, slot within word).
    function automatic loc_t map_xy(input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [31:0] cx;
        logic [31:0] cy;
        logic [31:0] idx;
        loc_t        loc;
        cx       = 32'(x >> SCALE_SHIFT);
        cy       = 32'(y >> SCALE_SHIFT);
        idx      = cy * CANVAS_W + cx;
        loc.ok   = (cx < CANVAS_W) && (cy < CANVAS_H);
        loc.word = AW'(idx / PPW);
        loc.slot = SW'(idx % PPW);
        return loc;
    endfunction

    logic [WORD_W-1:0] mem [WORDS];

    state_t            state_q;
    state_t            state_d;
    logic [AW-1:0]     sweep_q;
    logic              clear_pend_q;
    logic              wr_hs;
    loc_t              wr_loc;
    loc_t              rd_loc;

    logic [1:0]        op_q;
    logic [BPP-1:0]    color_q;
    logic [AW-1:0]     word_q;
    logic [SW-1:0]     slot_q;
    logic              ok_q;
    logic [WORD_W-1:0] rmw_q;

    logic [WORD_W-1:0] fill_word;
    logic [WORD_W-1:0] mask;
    logic [WORD_W-1:0] color_word;
    logic [WORD_W-1:0] merged;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    always_comb begin
        wr_loc = map_xy(bus.wr_x, bus.wr_y);
        rd_loc = map_xy(bus.rd_x, bus.rd_y);
    end

    assign wr_hs = bus.wr_valid && (state_q == IDLE);

`ifdef CANVAS_FILL_EN
    logic [BPP-1:0] fill_q;

    // Reset clears fill_q, so a reset-triggered sweep always writes zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
        end else if (state_q != CLEAR && state_d == CLEAR) begin
            fill_q <= fill_color;
        end
    end

    assign fill_word = {PPW{fill_q}};
`else
    assign fill_word = '0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR:   if (sweep_q == AW'(WORDS - 1)) state_d = IDLE;
            IDLE:    if (wr_hs) state_d = MODIFY;
                     else if (clear_req) state_d = CLEAR;
            MODIFY:  state_d = (clear_pend_q || clear_req) ? CLEAR : IDLE;
            default: state_d = CLEAR;
        endcase
    end

    // ---------------- FSM: outputs / memory write port ----------------
    always_comb begin
        busy         = 1'b0;
        bus.wr_ready = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = sweep_q;
        mem_wdata    = fill_word;
        unique case (state_q)
            CLEAR: begin
                busy   = 1'b1;
                mem_we = 1'b1;
            end
            IDLE: begin
                bus.wr_ready = 1'b1;
            end
            MODIFY: begin
                mem_we    = ok_q && (op_q != 2'b11);
                mem_addr  = word_q;
                mem_wdata = merged;
            end
            default: ;
        endcase
    end

    // Sweep address and pending clear. A clear seen together with a write
    // handshake is remembered so the sweep follows the MODIFY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_q      <= '0;
            clear_pend_q <= 1'b0;
        end else begin
            sweep_q <= (state_q == CLEAR && state_d == CLEAR) ? sweep_q + 1'b1 : '0;
            if (state_d == CLEAR) begin
                clear_pend_q <= 1'b0;
            end else if (clear_req && (wr_hs || state_q == MODIFY)) begin
                clear_pend_q <= 1'b1;
            end
        end
    end

    // Write request latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 2'b11;
            color_q <= '0;
            word_q  <= '0;
            slot_q  <= '0;
            ok_q    <= 1'b0;
        end else if (wr_hs) begin
            op_q    <= bus.wr_op;
            color_q <= bus.wr_color;
            word_q  <= wr_loc.word;
            slot_q  <= wr_loc.slot;
            ok_q    <= wr_loc.ok;
        end
    end

    // Merge of the latched pixel into the word read during the handshake.
    always_comb begin
        mask       = WORD_W'({BPP{1'b1}}) << (slot_q * BPP);
        color_word = WORD_W'(color_q) << (slot_q * BPP);
        unique case (op_q)
            2'b00:   merged = (rmw_q & ~mask) | color_word;
            2'b01:   merged = rmw_q & ~mask;
            2'b10:   merged = rmw_q ^ color_word;
            default: merged = rmw_q;
        endcase
    end

    // Storage: no reset, initialised by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (wr_hs && wr_loc.ok) begin
            rmw_q <= mem[wr_loc.word];
        end
    end

    // Scan-out read port, one cycle latency, zero outside the canvas.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data <= '0;
        end else if (rd_loc.ok) begin
            bus.rd_data <= BPP'(mem[rd_loc.word] >> (rd_loc.slot * BPP));
        end else begin
            bus.rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_canvas_framebuffer.sv
// -----------------------------------------------------------------------------
// tb_canvas_framebuffer
//   Bench for canvas_framebuffer. A 64x48, 2-bpp instance carries the pixel
//   tests against a pixel-array model; a default-parameter instance provides
//   sweep-length and mid-sweep reset checks. Read expectations go into a
//   queue when a read is issued and are popped by a separate monitor.
// -----------------------------------------------------------------------------
module tb_canvas_framebuffer;

    localparam int unsigned W      = 64;
    localparam int unsigned H      = 48;
    localparam int unsigned SS     = 1;
    localparam int unsigned BPPT   = 2;
    localparam int unsigned WW     = 32;
    localparam int unsigned M_WORDS = (W * H * BPPT + WW - 1) / WW;
    localparam int unsigned D_WORDS = (320 * 240 + 31) / 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clear_req = 1'b0;
    logic       d_clear_req = 1'b0;
    logic       busy;
    logic       d_busy;
    logic [1:0] fill_c = 2'b01;
    logic       d_fill = 1'b0;

    int errs = 0;
    int checks = 0;

    logic [1:0] model [H][W];
    logic [1:0] exp_q [$];
    string      nm_q [$];
    logic       rd_issue = 1'b0;
    logic       rd_tag = 1'b0;

    always #5 clk = ~clk;

    canvas_framebuffer_if #(.XW(10), .YW(9), .BPP(BPPT)) bus ();
    canvas_framebuffer_if #(.XW(10), .YW(9), .BPP(1))    d_bus ();

    canvas_framebuffer #(
        .CANVAS_W(W), .CANVAS_H(H), .SCALE_SHIFT(SS), .BPP(BPPT),
        .WORD_W(WW), .XW(10), .YW(9)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear_req(clear_req),
        .busy(busy),
`ifdef CANVAS_FILL_EN
        .fill_color(fill_c),
`endif
        .bus(bus)
    );

    canvas_framebuffer u_dflt (
        .clk(clk),
        .rst_n(rst_n),
        .clear_req(d_clear_req),
        .busy(d_busy),
`ifdef CANVAS_FILL_EN
        .fill_color(d_fill),
`endif
        .bus(d_bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_pix(input int unsigned x, input int unsigned y);
        int unsigned cx = x >> SS;
        int unsigned cy = y >> SS;
        if (cx < W && cy < H) return model[cy][cx];
        return 2'b00;
    endfunction

    function automatic logic [1:0] clr_val();
`ifdef CANVAS_FILL_EN
        return fill_c;
`else
        return 2'b00;
`endif
    endfunction

    task automatic model_fill(input logic [1:0] v);
        for (int unsigned y = 0; y < H; y++)
            for (int unsigned x = 0; x < W; x++)
                model[y][x] = v;
    endtask

    // Scoreboard monitor: a read issued in one cycle is checked the next.
    always @(posedge clk) rd_tag <= rd_issue;

    always @(negedge clk) begin
        if (rd_tag) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                chk(nm_q.pop_front(), {30'd0, bus.rd_data}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_read(input int unsigned x, input int unsigned y);
        bus.rd_x = 10'(x);
        bus.rd_y = 9'(y);
        exp_q.push_back(exp_pix(x, y));
        nm_q.push_back($sformatf("rd(%0d,%0d)", x, y));
        rd_issue = 1'b1;
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    task automatic do_write(input int unsigned x, input int unsigned y,
                            input logic [1:0] op, input logic [1:0] col, input logic clr);
        int n = 0;
        int unsigned cx = x >> SS;
        int unsigned cy = y >> SS;
        bus.wr_x     = 10'(x);
        bus.wr_y     = 9'(y);
        bus.wr_op    = op;
        bus.wr_color = col;
        bus.wr_valid = 1'b1;
        clear_req    = clr;
        while (!bus.wr_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.wr_ready) begin
            chk("wr_hs_timeout", 0, 1);
            bus.wr_valid = 1'b0;
            clear_req    = 1'b0;
            return;
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        clear_req    = 1'b0;
        chk("wr_ready_modify", {31'd0, bus.wr_ready}, 0);
        chk("busy_in_modify", {31'd0, busy}, 0);
        if (cx < W && cy < H) begin
            case (op)
                2'b00:   model[cy][cx] = col;
                2'b01:   model[cy][cx] = 2'b00;
                2'b10:   model[cy][cx] = model[cy][cx] ^ col;
                default: ;
            endcase
        end
        @(negedge clk);
        if (clr) begin
            chk("busy_after_modify", {31'd0, busy}, 1);
            chk("wr_ready_in_clear", {31'd0, bus.wr_ready}, 0);
            model_fill(clr_val());
        end else begin
            chk("wr_ready_back", {31'd0, bus.wr_ready}, 1);
        end
    endtask

    task automatic scan_all();
        for (int unsigned y = 0; y < H; y++)
            for (int unsigned x = 0; x < W; x++)
                do_read(x << SS, y << SS);
    endtask

    // Counts cycles from the current negedge until busy drops.
    task automatic wait_busy(input string nm, input int unsigned exp);
        int unsigned cnt = 0;
        while (busy && cnt < 10000) begin
            @(negedge clk);
            cnt++;
        end
        chk(nm, cnt, exp);
    endtask

    // Reset has just been released at a negedge: measure both sweeps.
    task automatic sweep_both();
        int unsigned m = 0;
        int unsigned d = 0;
        int unsigned cnt = 0;
        while ((m == 0 || d == 0) && cnt < 6000) begin
            @(negedge clk);
            cnt++;
            if (!busy && m == 0) m = cnt;
            if (!d_busy && d == 0) d = cnt;
        end
        chk("main_sweep_len", m, M_WORDS);
        chk("dflt_sweep_len", d, D_WORDS);
        chk("main_ready_after_sweep", {31'd0, bus.wr_ready}, 1);
        chk("dflt_ready_after_sweep", {31'd0, d_bus.wr_ready}, 1);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_op = 2'b11;
        bus.wr_color = '0; bus.rd_x = '0; bus.rd_y = '0;
        d_bus.wr_valid = 1'b0; d_bus.wr_x = '0; d_bus.wr_y = '0; d_bus.wr_op = 2'b11;
        d_bus.wr_color = '0; d_bus.rd_x = '0; d_bus.rd_y = '0;
        model_fill(2'b00);

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 1);
        chk("rst_wr_ready", {31'd0, bus.wr_ready}, 0);
        chk("rst_rd_data", {30'd0, bus.rd_data}, 0);
        chk("rst_dflt_busy", {31'd0, d_busy}, 1);
        rst_n = 1'b1;
        sweep_both();

        d_bus.rd_x = 10'd639; d_bus.rd_y = 9'd479;
        @(negedge clk);
        chk("dflt_rd_after_reset", {31'd0, d_bus.rd_data}, 0);
        scan_all();

        // Neighbouring slots of one word, then same-word overwrite.
        do_write(12, 4, 2'b00, 2'b01, 1'b0);
        do_write(10, 4, 2'b00, 2'b11, 1'b0);
        do_read(10, 4); do_read(8, 4); do_read(12, 4); do_read(14, 4);
        do_write(0, 0, 2'b10, 2'b01, 1'b0); do_read(0, 0);
        do_write(0, 0, 2'b10, 2'b01, 1'b0); do_read(0, 0);
        do_write(2, 0, 2'b00, 2'b10, 1'b0); do_read(2, 0);
        do_write(2, 0, 2'b01, 2'b11, 1'b0); do_read(2, 0);
        do_write(127, 95, 2'b00, 2'b10, 1'b0); do_read(127, 95);
        do_write(4, 4, 2'b11, 2'b11, 1'b0); do_read(4, 4);
        // Out-of-range writes must leave the whole canvas untouched.
        do_write(640, 0, 2'b00, 2'b11, 1'b0);
        do_write(0, 480, 2'b00, 2'b11, 1'b0);
        do_write(128, 0, 2'b00, 2'b11, 1'b0);
        do_write(0, 96, 2'b10, 2'b11, 1'b0);
        do_read(640, 0); do_read(0, 480); do_read(128, 0);
        scan_all();

        for (int i = 0; i < 80; i++) begin
            int unsigned x = $urandom_range(0, 140);
            int unsigned y = $urandom_range(0, 105);
            do_write(x, y, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
            do_read(x, y);
            do_read($urandom_range(0, 140), $urandom_range(0, 105));
        end
        scan_all();

        // Clear together with a write: write completes, then the sweep.
        do_write(2, 2, 2'b00, 2'b11, 1'b1);
        wait_busy("clr_with_write_len", M_WORDS);
        do_read(2, 2);
        scan_all();

        for (int i = 0; i < 20; i++)
            do_write($urandom_range(0, 127), $urandom_range(0, 95), 2'b00, 2'b10, 1'b0);

        // Clear from IDLE; a second request mid-sweep must not restart it.
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        model_fill(clr_val());
        chk("clr_idle_busy", {31'd0, busy}, 1);
        begin
            int unsigned cnt = 0;
            while (busy && cnt < 10000) begin
                @(negedge clk);
                cnt++;
                clear_req = (cnt == 50);
            end
            clear_req = 1'b0;
            chk("clr_ignored_len", cnt, M_WORDS);
        end
        scan_all();

        // Mid-sweep reset of the default instance at word 1000.
        do_write(20, 20, 2'b00, 2'b10, 1'b0);
        bus.rd_x = 10'd20; bus.rd_y = 9'd20;
        @(negedge clk);
        chk("rd_hold_before_reset", {30'd0, bus.rd_data}, {30'd0, model[10][10]});
        d_clear_req = 1'b1;
        @(negedge clk);
        d_clear_req = 1'b0;
        repeat (1000) @(negedge clk);
        chk("dflt_busy_mid_sweep", {31'd0, d_busy}, 1);
        chk("main_ready_before_reset", {31'd0, bus.wr_ready}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", {31'd0, busy}, 1);
        chk("async_wr_ready", {31'd0, bus.wr_ready}, 0);
        chk("async_rd_data", {30'd0, bus.rd_data}, 0);
        chk("async_dflt_busy", {31'd0, d_busy}, 1);
        chk("async_dflt_ready", {31'd0, d_bus.wr_ready}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_fill(2'b00);
        sweep_both();
        scan_all();

        repeat (3) @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
